// File: rtl/sipo_6bit_deserializer_if.sv
// Serial receive / parallel handshake bundle for sipo_6bit_deserializer.
// SIPO_PARITY_EN adds the parity_err output.
interface sipo_6bit_deserializer_if #(
  parameter int WIDTH = 6
);
  logic             si;
  logic             si_valid;
  logic             clear;
  logic             a_ack;
  logic [WIDTH-1:0] A;
  logic             a_valid;
  logic             overrun;
  logic [2:0]       cnt;
`ifdef SIPO_PARITY_EN
  logic             parity_err;

  modport master (
    output si, si_valid, clear, a_ack,
    input  A, a_valid, overrun, cnt, parity_err
  );
  modport slave (
    input  si, si_valid, clear, a_ack,
    output A, a_valid, overrun, cnt, parity_err
  );
`else
  modport master (
    output si, si_valid, clear, a_ack,
    input  A, a_valid, overrun, cnt
  );
  modport slave (
    input  si, si_valid, clear, a_ack,
    output A, a_valid, overrun, cnt
  );
`endif
endinterface

// File: rtl/sipo_6bit_deserializer.sv
// Serial-in/parallel-out word receiver with valid/ack holding register.
// Define SIPO_PARITY_EN for a trailing even-parity bit and parity_err.
module sipo_6bit_deserializer #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic Reset,
  sipo_6bit_deserializer_if.slave bus
);
`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic             a_valid_q;
  logic             overrun_q;
  logic             par_q;
  logic             last;
  logic             data_bit;
  logic             blocked;

  assign last     = int'(cnt_q) == FRAME - 1;
  assign data_bit = int'(cnt_q) < WIDTH;
  assign blocked  = a_valid_q && !bus.a_ack;

  // A frame always starts from an empty register, so nothing stale leaks in.
  always_comb begin
    sr_base = (state_q == IDLE) ? '0 : sr_q;
    sr_d    = sr_base;
    if (MSB_FIRST)
      sr_d = {sr_base[WIDTH-2:0], bus.si};
    else
      sr_d = {bus.si, sr_base[WIDTH-1:1]};
  end

`ifdef SIPO_PARITY_EN
  assign word = sr_q;
`else
  assign word = sr_d;
`endif

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      if (bus.a_ack)
        a_valid_q <= 1'b0;
      if (bus.clear) begin
        state_q <= IDLE;
        sr_q    <= '0;
        cnt_q   <= '0;
      end else if (bus.si_valid) begin
        if (last) begin
          state_q <= IDLE;
          sr_q    <= '0;
          cnt_q   <= '0;
          if (blocked) begin
            overrun_q <= 1'b1;
          end else begin
            a_q       <= word;
            a_valid_q <= 1'b1;
            par_q     <= ^sr_q ^ bus.si;
          end
        end else begin
          state_q <= SHIFT;
          cnt_q   <= cnt_q + CW'(1);
          if (data_bit)
            sr_q <= sr_d;
        end
      end
    end
  end

  assign bus.A       = a_q;
  assign bus.a_valid = a_valid_q;
  assign bus.overrun = overrun_q;
  assign bus.cnt     = 3'(cnt_q);
`ifdef SIPO_PARITY_EN
  assign bus.parity_err = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule
